// File: rtl/vedic_pkg.sv
// Shared types and constants for the sequential 16x16 Vedic multiplier.
package vedic_pkg;

  localparam int OPW  = 16;  // operand width
  localparam int PPW  = 16;  // partial-product width (8x8 result)
  localparam int ACCW = 32;  // accumulator / product width

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MUL   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Left shift applied to each partial product, indexed by step.
  localparam logic [4:0] SHIFT_S0 = 5'd0;
  localparam logic [4:0] SHIFT_S1 = 5'd8;
  localparam logic [4:0] SHIFT_S2 = 5'd8;
  localparam logic [4:0] SHIFT_S3 = 5'd16;

  function automatic logic [4:0] step_shift(input logic [1:0] step);
    logic [4:0] sh;
    case (step)
      2'd0:    sh = SHIFT_S0;
      2'd1:    sh = SHIFT_S1;
      2'd2:    sh = SHIFT_S2;
      2'd3:    sh = SHIFT_S3;
      default: sh = SHIFT_S0;
    endcase
    return sh;
  endfunction

  // Zero-extend a partial product to accumulator width, then shift it into place.
  function automatic logic [ACCW-1:0] pp_align(input logic [PPW-1:0] pp, input logic [4:0] sh);
    return {{(ACCW-PPW){1'b0}}, pp} << sh;
  endfunction

endpackage

// File: rtl/vedic_8bit_mul.sv
// Combinational 8x8 unsigned Vedic (Urdhva-Tiryagbhyam) multiplier, built
// recursively from 2x2 vertical-and-crosswise cells.
module vedic_8bit_mul (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] m
);

  function automatic logic [3:0] vm2(input logic [1:0] x, input logic [1:0] y);
    logic       t, u, c, h;
    logic [3:0] q;
    q[0] = x[0] & y[0];
    t    = x[1] & y[0];
    u    = x[0] & y[1];
    q[1] = t ^ u;
    c    = t & u;
    h    = x[1] & y[1];
    q[2] = h ^ c;
    q[3] = h & c;
    return q;
  endfunction

  function automatic logic [7:0] vm4(input logic [3:0] x, input logic [3:0] y);
    logic [3:0] ll, lh, hl, hh;
    logic [4:0] mid;
    ll  = vm2(x[1:0], y[1:0]);
    lh  = vm2(x[1:0], y[3:2]);
    hl  = vm2(x[3:2], y[1:0]);
    hh  = vm2(x[3:2], y[3:2]);
    mid = {1'b0, lh} + {1'b0, hl};
    return {4'd0, ll} + {1'b0, mid, 2'b00} + {hh, 4'd0};
  endfunction

  function automatic logic [15:0] vm8(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] ll, lh, hl, hh;
    logic [8:0] mid;
    ll  = vm4(x[3:0], y[3:0]);
    lh  = vm4(x[3:0], y[7:4]);
    hl  = vm4(x[7:4], y[3:0]);
    hh  = vm4(x[7:4], y[7:4]);
    mid = {1'b0, lh} + {1'b0, hl};
    return {8'd0, ll} + {3'b000, mid, 4'd0} + {hh, 8'd0};
  endfunction

  // Product of the two 8-bit operands.
  always_comb begin
    m = vm8(a, b);
  end

endmodule

// File: rtl/vedic_16bit_seq_mul.sv
// Sequential 16x16 unsigned multiplier: one shared 8x8 Vedic core, four
// partial-product steps accumulated into a 32-bit register, valid/ready on
// both sides. PIPE_MUL=1 registers the core output (one extra cycle).
module vedic_16bit_seq_mul
  import vedic_pkg::*;
#(
  parameter bit PIPE_MUL = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OPW-1:0]  a,
  input  logic [OPW-1:0]  b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ACCW-1:0] p,
  output logic            busy
);

  state_e          state_q;
  logic [1:0]      step_q;
  logic [OPW-1:0]  a_q, b_q;
  logic [ACCW-1:0] acc_q;
  logic [PPW-1:0]  pp_q;
  logic [4:0]      shift_q;
  logic            pp_vld_q;
  logic            in_ready_q, out_valid_q, busy_q;

  logic [7:0]      mul_a_s, mul_b_s;
  logic [PPW-1:0]  mul_m_s;
  logic [PPW-1:0]  acc_pp_s;
  logic [4:0]      acc_sh_s;
  logic            acc_en_s;
  logic [ACCW-1:0] acc_sum_s;

  // Operand mux: pick the byte pair for the current step.
  always_comb begin
    case (step_q)
      2'd0:    begin mul_a_s = a_q[7:0];  mul_b_s = b_q[7:0];  end
      2'd1:    begin mul_a_s = a_q[7:0];  mul_b_s = b_q[15:8]; end
      2'd2:    begin mul_a_s = a_q[15:8]; mul_b_s = b_q[7:0];  end
      2'd3:    begin mul_a_s = a_q[15:8]; mul_b_s = b_q[15:8]; end
      default: begin mul_a_s = 8'd0;      mul_b_s = 8'd0;      end
    endcase
  end

  vedic_8bit_mul u_mul (
    .a (mul_a_s),
    .b (mul_b_s),
    .m (mul_m_s)
  );

  // Accumulator input: live product with the current shift, or the registered
  // product with its delayed shift tag when the core output is pipelined.
  always_comb begin
    if (PIPE_MUL) begin
      acc_pp_s = pp_q;
      acc_sh_s = shift_q;
      acc_en_s = pp_vld_q;
    end else begin
      acc_pp_s = mul_m_s;
      acc_sh_s = step_shift(step_q);
      acc_en_s = (state_q == ST_MUL);
    end
    acc_sum_s = acc_q + pp_align(acc_pp_s, acc_sh_s);
  end

  // Control FSM, datapath registers and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      step_q      <= 2'd0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      pp_q        <= '0;
      shift_q     <= 5'd0;
      pp_vld_q    <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      pp_vld_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (in_valid && in_ready_q) begin
            a_q        <= a;
            b_q        <= b;
            acc_q      <= '0;
            step_q     <= 2'd0;
            state_q    <= ST_MUL;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end else begin
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
          end
        end
        ST_MUL: begin
          if (acc_en_s) begin
            acc_q <= acc_sum_s;
          end
          if (PIPE_MUL) begin
            pp_q     <= mul_m_s;
            shift_q  <= step_shift(step_q);
            pp_vld_q <= 1'b1;
          end
          step_q <= step_q + 2'd1;
          if (step_q == 2'd3) begin
            if (PIPE_MUL) begin
              state_q <= ST_DRAIN;
            end else begin
              state_q     <= ST_DONE;
              out_valid_q <= 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          acc_q       <= acc_sum_s;
          state_q     <= ST_DONE;
          out_valid_q <= 1'b1;
        end
        ST_DONE: begin
          if (out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign p         = acc_q;

endmodule
